uart_rx_os16: RTL and testbench
===============================

UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rxd  input  1  asynchronous serial line; idles high.
REQ-006 rx_ready  input  1  consumer accepts the held byte when high while rx_valid is high.
REQ-007 rx_data  output  8  received byte, held stable while rx_valid is high.
REQ-008 rx_valid  output  1  byte available; held until accepted.
REQ-009 rx_frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-010 rx_overrun  output  1  sticky flag: a good frame was dropped because rx_valid was high and not accepted.
REQ-011 rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer, both flops reset to 1; all logic uses only the synchronized value.
REQ-013 The 16x tick SHALL come from a free-running counter 0..DIV-1, with DIV = CLK_FREQ/(BAUD_RATE*16) using integer division. tick is high for one clk when the counter equals DIV-1.
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP. It advances only on tick cycles. A 4-bit sample counter cnt and a 3-bit bit index are reset on every state entry.
REQ-015 IDLE: on a tick with rxd low and arm=1, go to START with cnt=0. arm is set on any cycle with rxd high.
REQ-016 START: on the tick where cnt=7, if rxd is low go to DATA with cnt=0; if rxd is high (glitch), return to IDLE with no output activity.
REQ-017 DATA: on each tick where cnt=15, shift rxd into the MSB of an 8-bit shift register (LSB-first line order) and increment the bit index. After the 8th bit, go to STOP.
REQ-018 STOP: on the tick where cnt=15, sample rxd, then go to IDLE.
- Stop bit high: the frame is good.
- Stop bit low: pulse rx_frame_err for exactly one clk, deliver no data, and clear arm.
REQ-019 Good frame with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle: load rx_data and set rx_valid on the following clk edge. Latency is 1 clk after the stop-sample tick.
REQ-020 Good frame with rx_valid=1 and rx_ready=0: keep the old rx_data, drop the new byte, and set rx_overrun.
REQ-021 rx_valid SHALL clear on the clk after rx_ready=1 while rx_valid=1, unless a new byte loads in the same cycle (REQ-019).
REQ-022 rx_overrun SHALL clear on an accepting handshake (rx_valid=1 and rx_ready=1).
REQ-023 rx_ready while rx_valid=0 SHALL have no effect.
REQ-024 rx_data SHALL change only on a load.

Reset
REQ-025 rst SHALL immediately force:
- FSM to IDLE; baud counter, cnt and bit index to 0.
- Synchronizer flops to 1, arm=1.
- Shift register and rx_data to 0x00.
- rx_valid, rx_frame_err, rx_overrun and rx_busy to 0.
REQ-026 Reset mid-frame SHALL discard the partial frame. A frame starting after rst deasserts SHALL be received normally.

Verification (bench: CLK_FREQ=1600000, BAUD_RATE=10000, so DIV=10, 160 clk per bit)
REQ-027 Frame 0xA5 with good stop, rx_ready=0 -> rx_valid=1 and rx_data=0xA5 within 2 clk of the stop-bit middle; rx_frame_err=0; rx_busy low afterwards.
REQ-028 rxd low for 30 clk, then high -> rx_busy rises then falls; rx_valid and rx_frame_err stay 0.
REQ-029 Frame 0x3C with stop bit low, then line held low for 320 clk, then high -> one rx_frame_err pulse, rx_valid stays 0, rx_busy stays low until the line returns high; a following 0x5A frame is received correctly.
REQ-030 Frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, rx_overrun=1; one rx_ready pulse -> rx_valid=0 and rx_overrun=0 on the next clk.
REQ-031 rst pulsed mid-DATA of a 0xFF frame -> all outputs go to reset values immediately; next frame 0x5A yields rx_data=0x5A.
REQ-032 rx_ready held 1 with back-to-back frames 0x00 and 0xFF -> rx_valid is high for exactly 1 clk per frame with the correct data; rx_overrun stays 0.

Source files
------------

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a one-byte valid/ready holding
// register with sticky overrun and one-cycle frame-error reporting.
module uart_rx_os16 #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int unsigned Div    = CLK_FREQ / (BAUD_RATE * 16);
    // A divisor below 1 would be meaningless; clamp so tick fires every cycle instead.
    localparam int unsigned DivCnt = (Div > 1) ? Div : 1;
    localparam int unsigned DivW   = (DivCnt > 1) ? $clog2(DivCnt) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(DivCnt - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic            rxd_meta_q, rxd_meta_d;
    logic            rxd_sync_q, rxd_sync_d;
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            arm_q, arm_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            busy_q, busy_d;
    logic            tick;
    logic            frame_good;
    logic            accept;

    assign tick   = (div_q == DivMax);
    assign accept = valid_q & rx_ready;

    always_comb begin
        rxd_meta_d = rxd;
        rxd_sync_d = rxd_meta_q;
        div_d      = tick ? '0 : div_q + DivW'(1);
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        arm_d      = arm_q | rxd_sync_q;
        ferr_d     = 1'b0;
        frame_good = 1'b0;

        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rxd_sync_q && arm_q) begin
                        state_d   = StStart;
                        cnt_d     = 4'd0;
                        bit_idx_d = 3'd0;
                    end
                end
                StStart: begin
                    if (cnt_q == 4'd7) begin
                        state_d   = rxd_sync_q ? StIdle : StData;
                        cnt_d     = 4'd0;
                        bit_idx_d = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StData: begin
                    // cnt wraps 15 -> 0, which also restarts the count for the next bit.
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        shift_d   = {rxd_sync_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d   = StStop;
                            bit_idx_d = 3'd0;
                        end
                    end
                end
                StStop: begin
                    if (cnt_q == 4'd15) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                        if (rxd_sync_q) begin
                            frame_good = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                            arm_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        data_d  = data_q;
        valid_d = valid_q & ~rx_ready;
        ovr_d   = ovr_q & ~accept;
        if (frame_good) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            div_q      <= '0;
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            arm_q      <= 1'b1;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rxd_meta_q <= rxd_meta_d;
            rxd_sync_q <= rxd_sync_d;
            div_q      <= div_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            arm_q      <= arm_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: vector table, directed corner sequences and random
// frames checked against a frame-level model (160 clk per bit).
module tb_uart_rx_os16;

    localparam int unsigned ClkFreq  = 1600000;
    localparam int unsigned BaudRate = 10000;
    localparam int          BitClk   = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os16 #(
        .CLK_FREQ (ClkFreq),
        .BAUD_RATE(BaudRate)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_busy     (rx_busy)
    );

    // Output monitor: cumulative event counts, sampled on the falling edge.
    int         n_ferr = 0, n_ferr_long = 0, n_vrise = 0, n_vcyc = 0, n_brise = 0;
    int         last_rise_cyc = 0;
    logic [7:0] rise_data [256];
    logic       prev_v = 1'b0, prev_f = 1'b0, prev_b = 1'b0;

    always @(negedge clk) begin
        if (rx_frame_err) n_ferr <= n_ferr + 1;
        if (rx_frame_err && prev_f) n_ferr_long <= n_ferr_long + 1;
        if (rx_valid) n_vcyc <= n_vcyc + 1;
        if (rx_valid && !prev_v) begin
            rise_data[n_vrise[7:0]] <= rx_data;
            n_vrise       <= n_vrise + 1;
            last_rise_cyc <= cyc;
        end
        if (rx_busy && !prev_b) n_brise <= n_brise + 1;
        prev_v <= rx_valid;
        prev_f <= rx_frame_err;
        prev_b <= rx_busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic b, input int n);
        rxd = b;
        tick_wait(n);
    endtask

    // Leaves the line at the stop-bit level; callers choose what follows.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive(1'b0, BitClk);
        for (int i = 0; i < 8; i++) drive(d[i], BitClk);
        drive(stop, BitClk);
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        tick_wait(1);
        rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ack;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vt [7];

    initial begin
        int         f0, v0, vc0, b0, lat, gap, goods, bads;
        logic [7:0] d, first;
        logic       stop;
        logic [7:0] exp_q [$];

        rst      = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        tick_wait(3);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 8'h00);
        check("reset_ferr", rx_frame_err, 0);
        check("reset_ovr", rx_overrun, 0);
        check("reset_busy", rx_busy, 0);
        rst = 1'b0;
        tick_wait(20);

        // Good frame, consumer not ready.
        f0 = n_ferr; v0 = n_vrise;
        send_frame(8'hA5, 1'b1);
        drive(1'b1, 40);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_rises", n_vrise - v0, 1);
        // Stop middle is 1520 clk after the start edge; sync and tick phase add up to 12 clk.
        lat = last_rise_cyc - start_cyc;
        check("a5_latency", (lat >= 1520 && lat <= 1534), 1);
        check("a5_ferr", n_ferr - f0, 0);
        check("a5_busy", rx_busy, 0);
        pulse_ready();
        check("a5_ack_valid", rx_valid, 0);

        // Start-bit glitch.
        f0 = n_ferr; v0 = n_vrise; b0 = n_brise;
        drive(1'b0, 30);
        drive(1'b1, 200);
        check("glitch_busy_rise", n_brise - b0, 1);
        check("glitch_busy_now", rx_busy, 0);
        check("glitch_valid", n_vrise - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);

        // Bad stop bit followed by a stuck-low line.
        f0 = n_ferr; v0 = n_vrise;
        send_frame(8'h3C, 1'b0);
        b0 = n_brise;
        drive(1'b0, 320);
        check("ferr_pulses", n_ferr - f0, 1);
        check("ferr_no_rearm", n_brise - b0, 0);
        check("ferr_busy", rx_busy, 0);
        check("ferr_valid", n_vrise - v0, 0);
        drive(1'b1, 40);
        send_frame(8'h5A, 1'b1);
        drive(1'b1, 40);
        check("after_ferr_valid", rx_valid, 1);
        check("after_ferr_data", rx_data, 8'h5A);
        pulse_ready();

        // Vector table: frames sent with rx_ready low, optional handshake afterwards.
        vt[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 1'b0};
        vt[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b0};
        vt[2] = '{8'h11, 1'b1, 1'b1, 1'b1, 8'hA5, 0, 1'b1};
        vt[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 0, 1'b0};
        vt[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 1, 1'b0};
        vt[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h22, 1, 1'b0};
        vt[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            f0 = n_ferr;
            send_frame(vt[i].d, vt[i].stop);
            drive(1'b1, 40);
            check($sformatf("vec%0d_valid", i), rx_valid, vt[i].exp_valid);
            check($sformatf("vec%0d_data", i), rx_data, vt[i].exp_data);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, vt[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), rx_overrun, vt[i].exp_ovr);
            if (vt[i].ack) begin
                pulse_ready();
                check($sformatf("vec%0d_ack_valid", i), rx_valid, 0);
                check($sformatf("vec%0d_ack_ovr", i), rx_overrun, 0);
            end
        end

        // Overrun and its clearing handshake.
        send_frame(8'h11, 1'b1);
        drive(1'b1, 40);
        send_frame(8'h22, 1'b1);
        drive(1'b1, 40);
        check("ovr_valid", rx_valid, 1);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_flag", rx_overrun, 1);
        pulse_ready();
        check("ovr_ack_valid", rx_valid, 0);
        check("ovr_ack_flag", rx_overrun, 0);

        // Reset in the middle of a data bit with valid and overrun both set.
        send_frame(8'h33, 1'b1);
        drive(1'b1, 40);
        send_frame(8'h44, 1'b1);
        drive(1'b1, 40);
        check("pre_rst_ovr", rx_overrun, 1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick_wait(BitClk * 4);
                check("pre_rst_busy", rx_busy, 1);
                #3 rst = 1'b1;
                #1;
                check("rst_valid", rx_valid, 0);
                check("rst_data", rx_data, 8'h00);
                check("rst_ferr", rx_frame_err, 0);
                check("rst_ovr", rx_overrun, 0);
                check("rst_busy", rx_busy, 0);
                tick_wait(3);
                rst = 1'b0;
            end
        join
        f0 = n_ferr;
        drive(1'b1, 40);
        send_frame(8'h5A, 1'b1);
        drive(1'b1, 40);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'h5A);
        check("post_rst_ferr", n_ferr - f0, 0);
        pulse_ready();

        // Back-to-back frames with rx_ready held high.
        rx_ready = 1'b1;
        v0 = n_vrise; vc0 = n_vcyc;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive(1'b1, 40);
        check("b2b_rises", n_vrise - v0, 2);
        check("b2b_valid_cycles", n_vcyc - vc0, 2);
        check("b2b_data0", rise_data[v0[7:0]], 8'h00);
        check("b2b_data1", rise_data[(v0 + 1) & 255], 8'hFF);
        check("b2b_ovr", rx_overrun, 0);

        // Random frames, always-ready consumer: every good frame delivered in order.
        v0 = n_vrise; f0 = n_ferr; bads = 0;
        for (int i = 0; i < 8; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            if (stop) begin
                exp_q.push_back(d);
                gap = $urandom_range(0, 300);
            end else begin
                bads++;
                gap = $urandom_range(20, 300);
            end
            drive(1'b1, gap);
        end
        drive(1'b1, 40);
        check("rndA_count", n_vrise - v0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rndA_byte%0d", i), rise_data[(v0 + i) & 255], exp_q[i]);
        check("rndA_ferr", n_ferr - f0, bads);
        check("rndA_ovr", rx_overrun, 0);
        rx_ready = 1'b0;

        // Random frames, stalled consumer: first good byte held, overrun iff a second arrived.
        f0 = n_ferr; goods = 0; bads = 0; first = 8'h00;
        for (int i = 0; i < 6; i++) begin
            d    = 8'($urandom);
            stop = (i == 0) || ($urandom_range(0, 2) != 0);
            send_frame(d, stop);
            if (stop) begin
                if (goods == 0) first = d;
                goods++;
            end else begin
                bads++;
            end
            drive(1'b1, $urandom_range(20, 200));
        end
        check("rndB_valid", rx_valid, 1);
        check("rndB_data", rx_data, first);
        check("rndB_ovr", rx_overrun, (goods >= 2));
        check("rndB_ferr", n_ferr - f0, bads);
        pulse_ready();
        check("rndB_ack_valid", rx_valid, 0);
        check("rndB_ack_ovr", rx_overrun, 0);

        check("ferr_single_cycle", n_ferr_long, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
